// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end that shares one start/done GCD engine among NREQ requesters.
// Zero operands are answered directly; a WAIT-state watchdog aborts engines that never finish.
module gcd_rr_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_flat,
  input  logic [NREQ*WIDTH-1:0]   b_flat,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         resp_valid,
  output logic [WIDTH-1:0]        result,
  output logic                    err,
  output logic                    busy,
  output logic                    eng_start,
  output logic [WIDTH-1:0]        eng_a,
  output logic [WIDTH-1:0]        eng_b,
  output logic                    eng_abort,
  input  logic                    eng_done,
  input  logic [WIDTH-1:0]        eng_result
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW  = $clog2(TIMEOUT);

  localparam logic [IDW:0]   NREQ_W   = (IDW + 1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_id;
  logic [TW-1:0]     r_timer;
  logic [NREQ-1:0]   r_ack;
  logic [NREQ-1:0]   r_resp_valid;
  logic [WIDTH-1:0]  r_result;
  logic              r_err;
  logic              r_busy;
  logic              r_eng_start;
  logic [WIDTH-1:0]  r_eng_a;
  logic [WIDTH-1:0]  r_eng_b;
  logic              r_eng_abort;

  logic              w_gnt_any;
  logic [IDW-1:0]    w_gnt_id;
  logic [IDW:0]      w_cand;
  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;
  logic              w_bypass;

  // Search starts at r_ptr and wraps; the first requester found wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_ptr} + k[IDW:0];
      if (w_cand >= NREQ_W) w_cand = w_cand - NREQ_W;
      if (!w_gnt_any && req[w_cand[IDW-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = w_cand[IDW-1:0];
      end
    end
  end

  assign w_a      = a_flat[w_gnt_id*WIDTH +: WIDTH];
  assign w_b      = b_flat[w_gnt_id*WIDTH +: WIDTH];
  assign w_bypass = (w_a == '0) || (w_b == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_id         <= '0;
      r_timer      <= '0;
      r_ack        <= '0;
      r_resp_valid <= '0;
      r_result     <= '0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_eng_start  <= 1'b0;
      r_eng_a      <= '0;
      r_eng_b      <= '0;
      r_eng_abort  <= 1'b0;
    end else begin
      r_ack        <= '0;
      r_resp_valid <= '0;
      r_eng_start  <= 1'b0;
      r_eng_abort  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_any) begin
            r_id            <= w_gnt_id;
            r_eng_a         <= w_a;
            r_eng_b         <= w_b;
            r_busy          <= 1'b1;
            r_ack[w_gnt_id] <= 1'b1;
            if (w_bypass) begin
              // The subtractive engine never terminates on a zero operand.
              r_result               <= w_a | w_b;
              r_err                  <= 1'b0;
              r_resp_valid[w_gnt_id] <= 1'b1;
              r_state                <= S_RESP;
            end else begin
              r_eng_start <= 1'b1;
              r_timer     <= '0;
              r_state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_done) begin
            r_result           <= eng_result;
            r_err              <= 1'b0;
            r_resp_valid[r_id] <= 1'b1;
            r_state            <= S_RESP;
          end else if (r_timer == TMO_LAST) begin
            r_eng_abort        <= 1'b1;
            r_result           <= '0;
            r_err              <= 1'b1;
            r_resp_valid[r_id] <= 1'b1;
            r_state            <= S_RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RESP: begin
          r_ptr   <= (r_id == LAST_ID) ? '0 : r_id + 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack        = r_ack;
  assign resp_valid = r_resp_valid;
  assign result     = r_result;
  assign err        = r_err;
  assign busy       = r_busy;
  assign eng_start  = r_eng_start;
  assign eng_a      = r_eng_a;
  assign eng_b      = r_eng_b;
  assign eng_abort  = r_eng_abort;

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Bench for gcd_rr_scheduler: behavioural engine plus a transaction-level round-robin model.
module tb_gcd_rr_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int TMO   = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_flat;
  logic [NREQ*WIDTH-1:0] b_flat;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       resp_valid;
  logic [WIDTH-1:0]      result;
  logic                  err;
  logic                  busy;
  logic                  eng_start;
  logic [WIDTH-1:0]      eng_a;
  logic [WIDTH-1:0]      eng_b;
  logic                  eng_abort;
  logic                  eng_done;
  logic [WIDTH-1:0]      eng_result;

  logic                  m_done;
  logic [WIDTH-1:0]      m_res;
  logic                  stray;
  int                    m_cnt;
  bit                    m_run;
  int                    m_delay;
  bit                    m_hang;

  int                    n_chk  = 0;
  int                    n_pass = 0;
  int                    ptr_m  = 0;
  logic [WIDTH-1:0]      opa [NREQ];
  logic [WIDTH-1:0]      opb [NREQ];

  gcd_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .ack(ack), .resp_valid(resp_valid), .result(result), .err(err), .busy(busy),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b), .eng_abort(eng_abort),
    .eng_done(eng_done), .eng_result(eng_result)
  );

  always #5 clk = ~clk;

  assign eng_done   = m_done | stray;
  assign eng_result = m_res;

  function automatic logic [WIDTH-1:0] gcd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int unsigned p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return WIDTH'(p);
  endfunction

  // Engine: done pulse m_delay cycles after the start edge, never if m_hang.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_done <= 1'b0;
      m_run  <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
    end else begin
      m_done <= 1'b0;
      if (eng_abort) begin
        m_run <= 1'b0;
      end else if (eng_start) begin
        if (!m_hang) begin
          if (m_delay == 0) begin
            m_done <= 1'b1;
            m_res  <= gcd(eng_a, eng_b);
          end else begin
            m_run <= 1'b1;
            m_cnt <= m_delay;
          end
        end
      end else if (m_run) begin
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_res  <= gcd(eng_a, eng_b);
          m_run  <= 1'b0;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    opa[i] = a;
    opb[i] = b;
    a_flat[i*WIDTH +: WIDTH] = a;
    b_flat[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_rv"}, resp_valid, 0);
    check({tag, "_res"}, result, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, eng_start, 0);
    check({tag, "_enga"}, eng_a, 0);
    check({tag, "_engb"}, eng_b, 0);
    check({tag, "_abort"}, eng_abort, 0);
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    #1 check_all_zero("rst");
    step();
    step();
    #2 rst = 1'b0;
    ptr_m = 0;
  endtask

  // One arbitration round; entered with the next edge sampling req in IDLE.
  task automatic serve(input int dly, input bit hang, input bit stray_start);
    int               w, rc;
    bit               byp, to;
    logic [WIDTH-1:0] ea, eb, exp_res;
    w = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && req[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
    if (w < 0) begin
      check("no_request", 0, 1);
      return;
    end
    ea      = opa[w];
    eb      = opb[w];
    byp     = (ea == 0) || (eb == 0);
    to      = !byp && hang;
    exp_res = byp ? (ea | eb) : (to ? '0 : gcd(ea, eb));
    rc      = byp ? 1 : (to ? TMO + 2 : 3 + dly);
    m_hang  = hang;
    m_delay = dly;
    for (int c = 1; c <= rc; c++) begin
      step();
      if (c == 1) begin
        req[w] = 1'b0;
        set_op(w, WIDTH'($urandom), WIDTH'($urandom));
        if (stray_start) stray = 1'b1;
      end else begin
        stray = 1'b0;
      end
      check("ack", ack, (c == 1) ? (64'd1 << w) : 64'd0);
      check("resp_valid", resp_valid, (c == rc) ? (64'd1 << w) : 64'd0);
      check("eng_start", eng_start, (c == 1 && !byp) ? 1 : 0);
      check("eng_abort", eng_abort, (c == rc && to) ? 1 : 0);
      check("busy", busy, 1);
      if (c == 1 || c < rc) begin
        check("eng_a", eng_a, ea);
        check("eng_b", eng_b, eb);
      end
    end
    check("result", result, exp_res);
    check("err", err, to ? 1 : 0);
    step();
    check("busy_after", busy, 0);
    check("rv_after", resp_valid, 0);
    check("result_hold", result, exp_res);
    ptr_m = (w + 1) % NREQ;
  endtask

  initial begin
    int g;
    rst     = 1'b1;
    req     = '0;
    a_flat  = '0;
    b_flat  = '0;
    stray   = 1'b0;
    m_delay = 0;
    m_hang  = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, '0, '0);
    #1 check_all_zero("reset");
    step();
    #2 rst = 1'b0;

    set_op(0, 16'd78, 16'd143);
    req = 4'b0001;
    serve(12, 0, 0);

    apply_reset();
    set_op(0, 16'd12, 16'd18);
    set_op(1, 16'd35, 16'd14);
    set_op(2, 16'd9, 16'd6);
    set_op(3, 16'd100, 16'd75);
    req = 4'b1111;
    for (int j = 0; j < NREQ; j++) serve(j + 1, 0, 0);
    set_op(1, 16'd48, 16'd36);
    set_op(3, 16'd17, 16'd51);
    req = 4'b1010;
    serve(0, 0, 0);
    serve(2, 0, 0);

    set_op(0, 16'd0, 16'd21);
    req = 4'b0001;
    serve(3, 0, 0);
    set_op(1, 16'd0, 16'd0);
    req = 4'b0010;
    serve(3, 0, 0);

    set_op(2, 16'd91, 16'd65);
    req = 4'b0100;
    serve(0, 1, 0);
    set_op(3, 16'd64, 16'd24);
    req = 4'b1000;
    serve(5, 0, 0);

    set_op(0, 16'd221, 16'd91);
    req = 4'b0001;
    serve(TMO - 1, 0, 0);

    set_op(1, 16'd1000, 16'd250);
    req = 4'b0010;
    serve(4, 0, 1);
    stray = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      check("idle_done_rv", resp_valid, 0);
      check("idle_done_busy", busy, 0);
    end
    stray = 1'b0;
    step();

    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && ($urandom % 2 == 0)) begin
          g = $urandom_range(1, 60);
          set_op(i, ($urandom % 8 == 0) ? '0 : WIDTH'(g * $urandom_range(1, 900)),
                    ($urandom % 8 == 0) ? '0 : WIDTH'(g * $urandom_range(1, 900)));
          req[i] = 1'b1;
        end
      end
      if (req == '0) begin
        set_op(0, 16'd42, 16'd56);
        req[0] = 1'b1;
      end
      serve($urandom_range(0, TMO - 1), ($urandom % 8 == 0), ($urandom % 4 == 0));
    end
    while (req != '0) serve(1, 0, 0);

    set_op(2, 16'd30, 16'd42);
    req = 4'b0100;
    serve(3, 0, 0);
    set_op(2, 16'd50, 16'd70);
    req = 4'b0100;
    m_hang = 1'b1;
    step();
    check("rst_job_ack", ack, 4'b0100);
    req = '0;
    for (int j = 0; j < 4; j++) step();
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    ptr_m = 0;
    m_hang = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      check("rst_hold_rv", resp_valid, 0);
    end
    set_op(2, 16'd27, 16'd45);
    set_op(3, 16'd8, 16'd12);
    req = 4'b1100;
    #2 rst = 1'b0;
    serve(2, 0, 0);
    serve(2, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
